// File: rtl/spi_slave.sv
// SPI mode-0 slave front end of the SPI/RAM subsystem: deserialises MOSI frames
// into RAM command words and serialises RAM read data back onto MISO.
module spi_slave #(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int unsigned FRAME_W = ADDR_SIZE + 2;
    localparam int unsigned SHIFT_W = FRAME_W - 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHK   = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_SEND  = 2'd3;

    localparam logic [1:0] KIND_WR    = 2'd0;
    localparam logic [1:0] KIND_RADDR = 2'd1;
    localparam logic [1:0] KIND_RDATA = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           kind_q, kind_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 sending_q, sending_d;
    logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
    logic                 miso_q, miso_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_seen_q, rd_seen_d;

    // Full frame as it stands once the current MOSI bit is included.
    logic [FRAME_W-1:0]   frame_c;
    assign frame_c = {shift_q, MOSI};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kind_q     <= KIND_WR;
            shift_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            sending_q  <= 1'b0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            sending_q  <= sending_d;
            tx_sh_q    <= tx_sh_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        sending_d  = sending_q;
        tx_sh_d    = tx_sh_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_seen_d  = rd_seen_q;

        // Deselect aborts any frame; rd_seen survives so an aborted read can be retried.
        if (SS_n && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            miso_d    = 1'b0;
            cnt_d     = '0;
            done_d    = 1'b0;
            sending_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (!SS_n) begin
                        state_d   = S_CHK;
                        cnt_d     = '0;
                        done_d    = 1'b0;
                        sending_d = 1'b0;
                    end
                end
                S_CHK: begin
                    shift_d = {shift_q[SHIFT_W-2:0], MOSI};
                    cnt_d   = CNT_W'(1);
                    state_d = S_RECV;
                    if (!MOSI) begin
                        kind_d = KIND_WR;
                    end else if (rd_seen_q) begin
                        kind_d = KIND_RDATA;
                    end else begin
                        kind_d = KIND_RADDR;
                    end
                end
                S_RECV: begin
                    if (!done_q) begin
                        shift_d = {shift_q[SHIFT_W-2:0], MOSI};
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = frame_c;
                            rx_valid_d = 1'b1;
                            if ((kind_q == KIND_RADDR) && (frame_c[FRAME_W-1 -: 2] == 2'b10)) begin
                                rd_seen_d = 1'b1;
                            end
                            if (kind_q == KIND_RDATA) begin
                                state_d   = S_SEND;
                                sending_d = 1'b0;
                                cnt_d     = '0;
                            end else begin
                                done_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_SEND: begin
                    if (done_q) begin
                        miso_d = 1'b0;
                    end else if (!sending_q) begin
                        if (tx_valid) begin
                            miso_d    = tx_data[ADDR_SIZE-1];
                            tx_sh_d   = {tx_data[ADDR_SIZE-2:0], 1'b0};
                            sending_d = 1'b1;
                            cnt_d     = '0;
                        end
                    end else if (cnt_q == CNT_W'(ADDR_SIZE - 1)) begin
                        miso_d    = 1'b0;
                        rd_seen_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        miso_d  = tx_sh_q[ADDR_SIZE-1];
                        tx_sh_d = {tx_sh_q[ADDR_SIZE-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI-slave/single-port-RAM subsystem. Deserialises 10-bit MOSI frames into parallel words for the RAM (`rx_data`/`rx_valid`) and serialises the RAM's 8-bit read data (`tx_data`/`tx_valid`) back to the master on MISO. Runs directly on the SPI serial clock, mode 0, MSB first. A four-state FSM plus a read-address flag decides per frame whether to collect a write, a read address, or a read-data request.

## Interface
- `ADDR_SIZE`, 8: RAM address/data width; a frame is `ADDR_SIZE+2` bits.
- `clk`  in  1  SPI serial clock (SCK); all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data from master.
- `MISO`  out  1  serial data to master (registered).
- `rx_data`  out  `ADDR_SIZE+2`  completed frame; `[ADDR_SIZE+1:ADDR_SIZE]` is the command, `[ADDR_SIZE-1:0]` the payload.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is new.
- `tx_data`  in  `ADDR_SIZE`  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid.

## Operation
- States: IDLE, CHK_CMD, RECV, SEND. Internal `rd_addr_seen` flag, bit counter, shift registers.
- IDLE: `MISO`=0. `SS_n`=0 → CHK_CMD.
- CHK_CMD: samples frame bit `[ADDR_SIZE+1]` from MOSI into the shift register, then → RECV. Kind latched for the frame:
  - bit=0: write frame (00 address / 01 data).
  - bit=1 and `rd_addr_seen`=0: read-address frame.
  - bit=1 and `rd_addr_seen`=1: read-data frame.
- RECV: shifts in the remaining `ADDR_SIZE+1` bits, MSB first.
  - After the last bit, `rx_data` ← full frame and `rx_valid` pulses for one cycle.
  - Read-address frame with command 10: sets `rd_addr_seen`.
  - Write frame, or read-address frame with a command other than 10: stays in RECV, ignores MOSI and `rx_valid` stays 0 until `SS_n`=1.
  - Read-data frame: waits for `tx_valid`=1 and holds there indefinitely.
  - `tx_valid` is ignored outside the read-data wait.
- SEND: on the edge that sees `tx_valid`=1, latch `tx_data` and drive `MISO` ← `tx_data[ADDR_SIZE-1]`.
  - The next `ADDR_SIZE-1` edges shift out the remaining bits, down to bit 0.
  - The edge after bit 0: `MISO` ← 0 and `rd_addr_seen` cleared. MOSI is ignored until `SS_n`=1.
- `SS_n`=1 sampled in any non-IDLE state → IDLE next edge.
  - Partial frame discarded, no `rx_valid`, `MISO` ← 0.
  - `rd_addr_seen` unchanged, except that an aborted SEND leaves it set.
- `rx_data` holds its value between frames. Only the command bits of read-address frames are interpreted; all other frames are forwarded verbatim.

## Timing
- Reset (`rst`=1 at an edge) has priority over everything. Next-cycle values:
  - state IDLE
  - `MISO`=0, `rx_valid`=0, `rx_data`=0
  - `rd_addr_seen`=0, counters 0
  - Mid-frame reset drops the frame.
- Frame timing, with edge E0 the first edge that samples `SS_n`=0:
  - E0: IDLE → CHK_CMD.
  - E1..E10: MOSI bits 9..0 sampled.
  - E10: `rx_data` and `rx_valid` registered. `rx_valid`=1 during the cycle E10–E11, 0 from E11.
- Read path with the RAM at 1-cycle latency:
  - `tx_valid` seen at E11.
  - `MISO` carries bit 7 after E11 and bit 0 after E18.
  - `MISO`=0 after E19.
  - The master needs 19 clocks after SS_n falls.
- At most one `rx_valid` pulse per SS_n-low period.
- `SS_n` may rise one edge after the final bit. Back-to-back frames need `SS_n` high for ≥1 sampled edge.

## Test plan
- Reset: assert `rst` mid-RECV after 5 bits → next cycle `MISO`=0, `rx_valid`=0, `rx_data`=0. A following full frame decodes normally.
- Write: frames 00_0x2A then 01_0xC3 → `rx_data`=0x02A then 0x1C3. `rx_valid` exactly one cycle at E10 of each frame. `MISO` stays 0.
- Read pair: frame 10_0x2A → `rx_data`=0x22A and flag set. Frame 11_0x00 with `tx_valid`/`tx_data`=0xC3 at E11 → MISO 1,1,0,0,0,0,1,1 on E11..E18, then 0. Flag cleared: the next frame starting with 1 is a read-address frame.
- Abort: raise `SS_n` after 6 bits of 00_0x55 → no `rx_valid`, `rx_data` unchanged, state IDLE next edge.
- Abort SEND after 3 bits → IDLE. `rd_addr_seen` still 1, so a new 11 frame re-reads.
- Stall: read-data frame with `tx_valid` held 0 for 5 cycles → MISO stays 0. First bit appears on the edge `tx_valid` rises.
